// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache whole-line transactions onto one memory port.
// Define CACHE_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise D wins every tie.
module cache_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;   // 0 = I served last, 1 = D served last
  logic   i_req, d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
          state_d = last_grant_q ? SERVE_I : SERVE_D;
`else
          state_d = SERVE_D;
`endif
        end else if (d_req) begin
          state_d = SERVE_D;
        end else if (i_req) begin
          state_d = SERVE_I;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          state_d      = RECOVER;
          last_grant_d = 1'b0;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          state_d      = RECOVER;
          last_grant_d = 1'b1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant and address come from registered state; only the resp pulse is steered.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    unique case (state_q)
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
      end
      SERVE_D: begin
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_write   = d_pmem_write;
        pmem_address = d_pmem_address;
        d_pmem_resp  = pmem_resp;
      end
      default: ;
    endcase
  end

  assign pmem_wdata   = d_pmem_wdata;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(d_pmem_read && d_pmem_write))
        else $warning("cache_arbiter: d_pmem_read and d_pmem_write both high, treated as write");
      assert (!(state_q == SERVE_I && !i_pmem_read))
        else $warning("cache_arbiter: I request dropped while being served");
      assert (!(state_q == SERVE_D && !d_req))
        else $warning("cache_arbiter: D request dropped while being served");
      assert (!((state_q == IDLE || state_q == RECOVER) && pmem_resp))
        else $warning("cache_arbiter: pmem_resp with no transaction outstanding");
      assert (!$isunknown(last_grant_q))
        else $warning("cache_arbiter: last_grant unknown");
    end
  end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: table of single-requester line transactions
// plus hand sequences for ties, mid-transaction reset and the read+write corner.
module tb_cache_arbiter;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    bit                is_d;
    bit                rd;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    int                lat;
    bit                exp_read;
    bit                exp_write;
  } vec_t;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_pmem_read    = 1'b0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    pmem_resp      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    pmem_rdata = {8{32'hC0DE_F00D}};
    @(negedge clk);
    chk("rst.pmem_read",  pmem_read, 0);
    chk("rst.pmem_write", pmem_write, 0);
    chk("rst.pmem_addr",  pmem_address, 0);
    chk("rst.i_resp",     i_pmem_resp, 0);
    chk("rst.d_resp",     d_pmem_resp, 0);
    chk("rst.i_rdata",    i_pmem_rdata, {8{32'hC0DE_F00D}});
    chk("rst.d_rdata",    d_pmem_rdata, {8{32'hC0DE_F00D}});
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic do_txn(input vec_t v, input int idx);
    string t;
    t = $sformatf("txn%0d", idx);
    i_pmem_read    = !v.is_d;
    d_pmem_read    = v.is_d & v.rd;
    d_pmem_write   = v.is_d & v.wr;
    i_pmem_address = v.is_d ? ~v.addr : v.addr;
    d_pmem_address = v.is_d ? v.addr : ~v.addr;
    d_pmem_wdata   = v.wdata;
    @(negedge clk);
    chk({t, ".grant_lat"}, {pmem_read, pmem_write}, 2'b00);
    @(posedge clk); #1;
    for (int c = 1; c <= v.lat; c++) begin
      if (c == v.lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = v.rdata;
      end
      @(negedge clk);
      chk($sformatf("%s.c%0d.read", t, c),  pmem_read, v.exp_read);
      chk($sformatf("%s.c%0d.write", t, c), pmem_write, v.exp_write);
      chk($sformatf("%s.c%0d.addr", t, c),  pmem_address, v.addr);
      chk($sformatf("%s.c%0d.wdata", t, c), pmem_wdata, v.wdata);
      chk($sformatf("%s.c%0d.i_resp", t, c), i_pmem_resp, (c == v.lat) && !v.is_d);
      chk($sformatf("%s.c%0d.d_resp", t, c), d_pmem_resp, (c == v.lat) && v.is_d);
      if (c == v.lat)
        chk({t, ".rdata"}, v.is_d ? d_pmem_rdata : i_pmem_rdata, v.rdata);
      @(posedge clk); #1;
    end
    pmem_resp = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk({t, ".recover.strobes"}, {pmem_read, pmem_write}, 2'b00);
    chk({t, ".recover.addr"}, pmem_address, 0);
    chk({t, ".recover.resps"}, {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk({t, ".idle.strobes"}, {pmem_read, pmem_write}, 2'b00);
    @(posedge clk); #1;
  endtask

  // Memory model for contention runs: respond on the lat-th strobe cycle.
  task automatic serve_one(input int lat, output int who);
    int cnt;
    cnt = 0;
    who = -1;
    for (int cyc = 0; cyc < 40 && who < 0; cyc++) begin
      @(negedge clk);
      if (pmem_read | pmem_write) cnt++;
      if (cnt == lat) begin
        pmem_resp = 1'b1;
        #1;
        if (i_pmem_resp && !d_pmem_resp)      who = 0;
        else if (d_pmem_resp && !i_pmem_resp) who = 1;
        else                                  who = 2;
      end
    end
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    if (who == 0) i_pmem_read = 1'b0;
    if (who == 1) d_pmem_read = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    int who;
    int exp_who;
    vec_t v;

    vecs[0] = '{is_d:0, rd:0, wr:0, addr:32'h0000_1000, wdata:{8{32'h0F0F_0F0F}},
                rdata:{8{32'hAAAA_AAAA}}, lat:4, exp_read:1, exp_write:0};
    vecs[1] = '{is_d:1, rd:0, wr:1, addr:32'h0000_2000, wdata:{8{32'h5555_5555}},
                rdata:{8{32'h1234_5678}}, lat:3, exp_read:0, exp_write:1};
    vecs[2] = '{is_d:1, rd:1, wr:0, addr:32'h0000_3000, wdata:{8{32'h0000_0000}},
                rdata:{4{64'h0123_4567_89AB_CDEF}}, lat:1, exp_read:1, exp_write:0};
    vecs[3] = '{is_d:0, rd:0, wr:0, addr:32'hFFFF_FFC0, wdata:{8{32'hDEAD_BEEF}},
                rdata:{8{32'hFFFF_FFFF}}, lat:2, exp_read:1, exp_write:0};
    vecs[4] = '{is_d:1, rd:1, wr:1, addr:32'h0000_4000, wdata:{8{32'h3C3C_3C3C}},
                rdata:{8{32'h9999_9999}}, lat:2, exp_read:0, exp_write:1};

    rst = 1'b1;
    idle_inputs();
    i_pmem_address = '0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;

    do_reset();
    for (int k = 0; k < 5; k++) do_txn(vecs[k], k);

    // Reset while SERVE_D waits: strobe drops after the edge, late resp is not forwarded.
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_2000;
    d_pmem_wdata   = {8{32'h5555_5555}};
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid.write_before", pmem_write, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    d_pmem_write = 1'b0;
    @(posedge clk); #1;
    pmem_resp = 1'b1;
    @(negedge clk);
    chk("rstmid.strobes", {pmem_read, pmem_write}, 2'b00);
    chk("rstmid.d_resp", d_pmem_resp, 0);
    chk("rstmid.i_resp", i_pmem_resp, 0);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    rst = 1'b0;
    v = vecs[0];
    v.addr = 32'h0000_5000;
    do_txn(v, 10);

    // Sustained simultaneous requests from reset.
    do_reset();
    i_pmem_read    = 1'b1;
    d_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_6000;
    d_pmem_address = 32'h0000_7000;
    for (int k = 0; k < 10; k++) begin
      serve_one(2, who);
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      exp_who = k % 2;
`else
      exp_who = 1;
`endif
      chk($sformatf("tie%0d.winner", k), who, exp_who);
      @(negedge clk);
      chk($sformatf("tie%0d.recover", k), {pmem_read, pmem_write}, 2'b00);
      @(posedge clk); #1;
      i_pmem_read = 1'b1;
      d_pmem_read = 1'b1;
    end
    idle_inputs();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
